ook_frame_keyer: RTL and testbench

Parametrised on-off-keying frame keyer for the fan-remote transmitter. It sits in the 10 MHz PLL output domain and drives the gate that passes the 350 MHz LO to the antenna pin. It accepts a command word, pulse-width encodes it into chips, and repeats it a programmable number of times with inter-frame gaps. Transmission is interlocked to a qualified PLL lock: the LO is never keyed while the synthesiser is unlocked.

---
 rtl/ook_frame_keyer.sv | 179 +++++++++++++++++
 tb/tb_ook_frame_keyer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ook_frame_keyer.sv
// On-off-keying frame keyer: pulse-width encodes a command word into chips,
// repeats it with inter-frame gaps, and never keys the LO without qualified PLL lock.
module ook_frame_keyer #(
  parameter int unsigned FRAME_BITS  = 24,
  parameter int unsigned CHIP_TICKS  = 4000,
  parameter int unsigned REPEATS     = 4,
  parameter int unsigned GAP_CHIPS   = 25,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  ready,
  output logic                  busy,
  output logic                  key,
  output logic                  done,
  output logic                  abort
);

  localparam int unsigned TW = (CHIP_TICKS > 1) ? $clog2(CHIP_TICKS) : 1;
  localparam int unsigned BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned GW = (GAP_CHIPS > 1) ? $clog2(GAP_CHIPS) : 1;
  localparam int unsigned RW = $clog2(REPEATS + 1);
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state;
  logic [LW-1:0]         lock_cnt;
  logic [LW-1:0]         lock_cnt_nxt;
  logic                  lock_ok_nxt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_q;
  logic [TW-1:0]         tick;
  logic [1:0]            chip;
  logic [BW-1:0]         bit_idx;
  logic [GW-1:0]         gap_cnt;
  logic [RW-1:0]         rep;
  logic                  tick_wrap;

  // Lock qualifier: consecutive-high counter, saturating, cleared by any low cycle.
  always_comb begin
    lock_cnt_nxt = lock_cnt;
    if (!pll_lock) begin
      lock_cnt_nxt = '0;
    end else if (lock_cnt != LW'(LOCK_CYCLES)) begin
      lock_cnt_nxt = lock_cnt + LW'(1);
    end
  end

  assign lock_ok_nxt = (lock_cnt_nxt == LW'(LOCK_CYCLES));
  assign tick_wrap   = (tick == TW'(CHIP_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
      shreg    <= '0;
      frame_q  <= '0;
      tick     <= '0;
      chip     <= '0;
      bit_idx  <= '0;
      gap_cnt  <= '0;
      rep      <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      key      <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_nxt;
      done     <= 1'b0;
      abort    <= 1'b0;
      ready    <= 1'b0;
      case (state)
        IDLE: begin
          key  <= 1'b0;
          busy <= 1'b0;
          if (start && ready) begin
            if (!pll_lock) begin
              // Lock lost on the accept edge: refuse to key, report abort.
              abort <= 1'b1;
            end else begin
              state   <= SEND;
              shreg   <= frame;
              frame_q <= frame;
              rep     <= '0;
              tick    <= '0;
              chip    <= '0;
              bit_idx <= '0;
              busy    <= 1'b1;
              key     <= 1'b1;
            end
          end else begin
            ready <= lock_ok_nxt;
          end
        end

        SEND: begin
          if (!pll_lock) begin
            state <= IDLE;
            busy  <= 1'b0;
            key   <= 1'b0;
            abort <= 1'b1;
          end else if (!tick_wrap) begin
            tick <= tick + TW'(1);
          end else begin
            tick <= '0;
            case (chip)
              2'd0: begin
                chip <= 2'd1;
                key  <= shreg[FRAME_BITS-1];
              end
              2'd1: begin
                chip <= 2'd2;
                key  <= 1'b0;
              end
              default: begin
                chip <= 2'd0;
                if (bit_idx == BW'(FRAME_BITS - 1)) begin
                  state   <= GAP;
                  gap_cnt <= '0;
                  key     <= 1'b0;
                end else begin
                  bit_idx <= bit_idx + BW'(1);
                  shreg   <= shreg << 1;
                  key     <= 1'b1;
                end
              end
            endcase
          end
        end

        GAP: begin
          key <= 1'b0;
          if (!pll_lock) begin
            state <= IDLE;
            busy  <= 1'b0;
            abort <= 1'b1;
          end else if (!tick_wrap) begin
            tick <= tick + TW'(1);
          end else begin
            tick <= '0;
            if (gap_cnt != GW'(GAP_CHIPS - 1)) begin
              gap_cnt <= gap_cnt + GW'(1);
            end else begin
              rep <= rep + RW'(1);
              if (rep + RW'(1) == RW'(REPEATS)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                ready <= lock_ok_nxt;
              end else begin
                state   <= SEND;
                shreg   <= frame_q;
                chip    <= '0;
                bit_idx <= '0;
                key     <= 1'b1;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          key   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ook_frame_keyer.sv
// Directed bench for ook_frame_keyer with small parameters (4-bit frames,
// 2-tick chips, 2 repeats, 3-chip gaps, 8-cycle lock qualification).
module tb_ook_frame_keyer;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       start;
  logic [3:0] frame;
  logic       ready;
  logic       busy;
  logic       key;
  logic       done;
  logic       abort;

  int n_cmp;
  int n_bad;

  ook_frame_keyer #(
    .FRAME_BITS (4),
    .CHIP_TICKS (2),
    .REPEATS    (2),
    .GAP_CHIPS  (3),
    .LOCK_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pll_lock(pll_lock),
    .start   (start),
    .frame   (frame),
    .ready   (ready),
    .busy    (busy),
    .key     (key),
    .done    (done),
    .abort   (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_lock = 1'b1; start = 1'b0; frame = 4'h0;
    step(); step();
    n_cmp++;
    if ({ready, busy, key, done, abort} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy/bsy/key/done/abrt=%b want 00000",
               {ready, busy, key, done, abort});
    end
    rst_n = 1'b1;
  endtask

  // Holds pll_lock high and checks ready rises on exactly the 8th cycle.
  task automatic qualify(input string tag);
    pll_lock = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++;
      if (ready !== (i == 8)) begin
        n_bad++;
        $display("FAIL %s_ready_c%0d: got %b want %b", tag, i, ready, (i == 8));
      end
    end
  endtask

  task automatic test_lock_qualification();
    test_reset();
    start = 1'b1;  // before qualification: must be ignored
    qualify("lockq");
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || key !== 1'b0) begin
      n_bad++;
      $display("FAIL early_start_ignored: got busy=%b key=%b want 0 0", busy, key);
    end
    test_reset();
    pll_lock = 1'b1;
    repeat (5) step();
    pll_lock = 1'b0;
    step();
    qualify("relock");
  endtask

  // Accepts frame f (ready must be high) and checks 60 busy cycles against pat,
  // the count of key-high cycles in the first frame body, then the done cycle.
  task automatic send_frame(input string tag, input logic [3:0] f,
                            input logic [29:0] pat, input int exp_high,
                            input bit poke_start);
    int highs;
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_pre_ready: got %b want 1", tag, ready);
    end
    frame = f; start = 1'b1;
    step();
    start = 1'b0; frame = ~f;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ready_low: got %b want 0", tag, ready);
    end
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      start = poke_start && (i == 7 || i == 33);
      n_cmp++;
      if (key !== pat[29 - (i % 30)] || busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_trace_c%0d: got key=%b busy=%b done=%b want key=%b busy=1 done=0",
                 tag, i + 1, key, busy, done, pat[29 - (i % 30)]);
      end
      if (i < 24 && key === 1'b1) highs++;
      step();
    end
    start = 1'b0;
    n_cmp++;
    if (highs != exp_high) begin
      n_bad++;
      $display("FAIL %s_high_count: got %0d want %0d", tag, highs, exp_high);
    end
    n_cmp++;
    if ({busy, key, done, ready, abort} !== 5'b00110) begin
      n_bad++;
      $display("FAIL %s_done_cycle: got bsy/key/done/rdy/abrt=%b want 00110",
               tag, {busy, key, done, ready, abort});
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_after_done: got done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_nominal();
    logic [29:0] pat;
    pat = 30'b111100110000111100110000000000;
    send_frame("nom1010", 4'b1010, pat, 12, 1'b0);
  endtask

  task automatic test_extremes();
    logic [29:0] pat;
    pat = 30'b110000110000110000110000000000;
    send_frame("all0", 4'b0000, pat, 8, 1'b0);
    pat = 30'b111100111100111100111100000000;
    send_frame("all1", 4'b1111, pat, 16, 1'b0);
  endtask

  task automatic test_ignored_start();
    logic [29:0] pat;
    pat = 30'b111100110000111100110000000000;
    send_frame("ignstart", 4'b1010, pat, 12, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [29:0] pat;
    pat = 30'b111100111100110000110000000000;
    send_frame("b2b_a", 4'b1100, pat, 12, 1'b0);
    pat = 30'b110000111100111100110000000000;
    send_frame("b2b_b", 4'b0110, pat, 12, 1'b0);
  endtask

  task automatic test_lock_loss();
    logic [29:0] pat;
    pat = 30'b111100110000111100110000000000;
    frame = 4'b1010; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (key !== pat[29 - i]) begin
        n_bad++;
        $display("FAIL loss_pre_c%0d: got key=%b want %b", i + 1, key, pat[29 - i]);
      end
      if (i < 19) step();
    end
    pll_lock = 1'b0;
    step();
    n_cmp++;
    if ({key, busy, abort, done, ready} !== 5'b00100) begin
      n_bad++;
      $display("FAIL loss_abort: got key/bsy/abrt/done/rdy=%b want 00100",
               {key, busy, abort, done, ready});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({key, busy, abort, done, ready} !== 5'b00000) begin
        n_bad++;
        $display("FAIL loss_quiet_c%0d: got key/bsy/abrt/done/rdy=%b want 00000",
                 i, {key, busy, abort, done, ready});
      end
    end
    qualify("loss_requal");
  endtask

  task automatic test_loss_on_accept();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL acc_loss_pre_ready: got %b want 1", ready);
    end
    frame = 4'b1111; start = 1'b1; pll_lock = 1'b0;
    step();
    start = 1'b0;
    n_cmp++;
    if ({key, busy, abort, ready} !== 4'b0010) begin
      n_bad++;
      $display("FAIL acc_loss: got key/bsy/abrt/rdy=%b want 0010", {key, busy, abort, ready});
    end
    step();
    n_cmp++;
    if ({key, busy, abort} !== 3'b000) begin
      n_bad++;
      $display("FAIL acc_loss_after: got key/bsy/abrt=%b want 000", {key, busy, abort});
    end
    qualify("acc_requal");
  endtask

  task automatic test_reset_mid();
    logic [29:0] pat;
    frame = 4'b0101; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({ready, busy, key, done, abort} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_mid: got rdy/bsy/key/done/abrt=%b want 00000",
               {ready, busy, key, done, abort});
    end
    rst_n = 1'b1;
    qualify("rst_requal");
    pat = 30'b111100111100110000110000000000;
    send_frame("after_rst", 4'b1100, pat, 12, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_lock_qualification();
    test_nominal();
    test_extremes();
    test_ignored_start();
    test_back_to_back();
    test_lock_loss();
    test_loss_on_accept();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
